// File: rtl/apb_txn_scheduler.sv
// apb_txn_scheduler: sequences AXI bursts onto a single APB master.
//
// Arbitrates round-robin between pending AW and AR requests. Each granted burst
// is expanded into per-beat APB transfers with FIXED/INCR/WRAP address
// generation and PSEL decode. Beats are gated on write-FIFO data or read-FIFO
// space. Per-beat read status and a single write response are returned.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_req_* / rd_req_*        AW / AR request (valid/ready + addr/len/size/burst)
//   wfifo_empty, rfifo_full    FIFO gating for write / read beats
//   apb_start                  one-cycle launch pulse for one APB transfer
//   apb_write/addr/sel         transfer attributes, stable from SETUP until apb_done
//   apb_done, apb_err          transfer completion and PSLVERR
//   rd_beat_valid/resp/last    per-beat read status
//   wr_resp_valid/resp/ready   write burst response handshake
module apb_txn_scheduler #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SEL_BIT    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [3:0]            wr_req_len,
    input  logic [2:0]            wr_req_size,
    input  logic [1:0]            wr_req_burst,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [3:0]            rd_req_len,
    input  logic [2:0]            rd_req_size,
    input  logic [1:0]            rd_req_burst,
    input  logic                  wfifo_empty,
    input  logic                  rfifo_full,
    output logic                  apb_start,
    output logic                  apb_write,
    output logic [ADDR_WIDTH-1:0] apb_addr,
    output logic [1:0]            apb_sel,
    input  logic                  apb_done,
    input  logic                  apb_err,
    output logic                  rd_beat_valid,
    output logic [1:0]            rd_beat_resp,
    output logic                  rd_beat_last,
    output logic                  wr_resp_valid,
    output logic [1:0]            wr_resp,
    input  logic                  wr_resp_ready
);

    typedef enum logic [1:0] {StIdle, StSetup, StWait, StResp} state_e;
    typedef enum logic [1:0] {ModeFixed, ModeIncr, ModeWrap} mode_e;

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic                  unsup_q, unsup_d;
    logic                  err_sticky_q, err_sticky_d;
    logic                  last_wr_q, last_wr_d;  // 1: last grant went to write

    // Round-robin: on a tie the side not granted last time wins.
    logic grant_wr, grant_rd;
    assign grant_wr = wr_req_valid & (~rd_req_valid | ~last_wr_q);
    assign grant_rd = rd_req_valid & ~grant_wr;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            req_len;
    logic [2:0]            req_size;
    logic [1:0]            req_burst;
    logic                  req_wrap_ok, req_unsup;
    mode_e                 req_mode;
    logic [1:0]            req_size_clamped;

    always_comb begin
        req_addr  = grant_wr ? wr_req_addr  : rd_req_addr;
        req_len   = grant_wr ? wr_req_len   : rd_req_len;
        req_size  = grant_wr ? wr_req_size  : rd_req_size;
        req_burst = grant_wr ? wr_req_burst : rd_req_burst;

        req_wrap_ok = (req_burst == 2'b10) && (req_len inside {4'd1, 4'd3, 4'd7, 4'd15});
        req_unsup   = (req_size > 3'd2) || (req_burst == 2'b11) ||
                      ((req_burst == 2'b10) && !req_wrap_ok);
        req_size_clamped = (req_size > 3'd2) ? 2'd2 : req_size[1:0];

        // Illegal WRAP and reserved burst type fall back to INCR.
        if (req_burst == 2'b00) begin
            req_mode = ModeFixed;
        end else if (req_wrap_ok) begin
            req_mode = ModeWrap;
        end else begin
            req_mode = ModeIncr;
        end
    end

    // Next beat address.
    logic [ADDR_WIDTH-1:0] incr, wrap_mask, incr_addr, next_addr;
    always_comb begin
        incr      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        incr_addr = addr_q + incr;
        unique case (mode_q)
            ModeFixed: next_addr = addr_q;
            ModeWrap:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:   next_addr = incr_addr;
        endcase
    end

    logic active;
    assign active    = (state_q == StSetup) || (state_q == StWait);
    assign apb_addr  = active ? addr_q : '0;
    assign apb_sel   = active ? (addr_q[SEL_BIT] ? 2'b10 : 2'b01) : 2'b00;
    assign apb_write = active & write_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        size_d       = size_q;
        write_d      = write_q;
        unsup_d      = unsup_q;
        err_sticky_d = err_sticky_q;
        last_wr_d    = last_wr_q;

        wr_req_ready  = 1'b0;
        rd_req_ready  = 1'b0;
        apb_start     = 1'b0;
        rd_beat_valid = 1'b0;
        rd_beat_resp  = 2'b00;
        rd_beat_last  = 1'b0;
        wr_resp_valid = 1'b0;
        wr_resp       = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (grant_wr || grant_rd) begin
                    wr_req_ready = grant_wr;
                    rd_req_ready = grant_rd;
                    addr_d       = req_addr;
                    len_d        = req_len;
                    size_d       = req_size_clamped;
                    mode_d       = req_mode;
                    unsup_d      = req_unsup;
                    write_d      = grant_wr;
                    last_wr_d    = grant_wr;
                    err_sticky_d = 1'b0;
                    beat_cnt_d   = 4'd0;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                if (!((write_q && wfifo_empty) || (!write_q && rfifo_full))) begin
                    apb_start = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (apb_done) begin
                    if (write_q) begin
                        err_sticky_d = err_sticky_q | apb_err;
                    end else begin
                        rd_beat_valid = 1'b1;
                        rd_beat_resp  = (apb_err || unsup_q) ? 2'b10 : 2'b00;
                        rd_beat_last  = (beat_cnt_q == len_q);
                    end
                    if (beat_cnt_q == len_q) begin
                        state_d = write_q ? StResp : StIdle;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        addr_d     = next_addr;
                        state_d    = StSetup;
                    end
                end
            end
            StResp: begin
                wr_resp_valid = 1'b1;
                wr_resp       = (err_sticky_q || unsup_q) ? 2'b10 : 2'b00;
                if (wr_resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= ModeFixed;
            addr_q       <= '0;
            len_q        <= 4'd0;
            beat_cnt_q   <= 4'd0;
            size_q       <= 2'd0;
            write_q      <= 1'b0;
            unsup_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            last_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            size_q       <= size_d;
            write_q      <= write_d;
            unsup_q      <= unsup_d;
            err_sticky_q <= err_sticky_d;
            last_wr_q    <= last_wr_d;
        end
    end

endmodule

// File: tb/tb_apb_txn_scheduler.sv
// Self-checking bench for apb_txn_scheduler: directed cases plus randomized bursts
// checked against a burst-level reference model (address lists, grant order, responses).
module tb_apb_txn_scheduler;

    localparam int unsigned AW  = 32;
    localparam int unsigned SEL = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [3:0]    wr_req_len;
    logic [2:0]    wr_req_size;
    logic [1:0]    wr_req_burst;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic [3:0]    rd_req_len;
    logic [2:0]    rd_req_size;
    logic [1:0]    rd_req_burst;
    logic          wfifo_empty, rfifo_full;
    logic          apb_start, apb_write;
    logic [AW-1:0] apb_addr;
    logic [1:0]    apb_sel;
    logic          apb_done, apb_err;
    logic          rd_beat_valid;
    logic [1:0]    rd_beat_resp;
    logic          rd_beat_last;
    logic          wr_resp_valid;
    logic [1:0]    wr_resp;
    logic          wr_resp_ready;

    always #5 clk = ~clk;

    apb_txn_scheduler #(.ADDR_WIDTH(AW), .SEL_BIT(SEL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_len    (wr_req_len),
        .wr_req_size   (wr_req_size),
        .wr_req_burst  (wr_req_burst),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_len    (rd_req_len),
        .rd_req_size   (rd_req_size),
        .rd_req_burst  (rd_req_burst),
        .wfifo_empty   (wfifo_empty),
        .rfifo_full    (rfifo_full),
        .apb_start     (apb_start),
        .apb_write     (apb_write),
        .apb_addr      (apb_addr),
        .apb_sel       (apb_sel),
        .apb_done      (apb_done),
        .apb_err       (apb_err),
        .rd_beat_valid (rd_beat_valid),
        .rd_beat_resp  (rd_beat_resp),
        .rd_beat_last  (rd_beat_last),
        .wr_resp_valid (wr_resp_valid),
        .wr_resp       (wr_resp),
        .wr_resp_ready (wr_resp_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          size;
        int          burst;
        logic [15:0] errs;   // apb_err per beat index
        int          stall;  // FIFO-gated cycles before each beat
        int          hold;   // cycles before wr_resp_ready
    } req_t;

    int errors = 0;
    int checks = 0;
    bit last_wr;  // model: 1 when the previous grant was a write

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_unsup(input req_t r);
        bit wrap_len_ok = (r.len == 1) || (r.len == 3) || (r.len == 7) || (r.len == 15);
        return (r.size > 2) || (r.burst == 3) || (r.burst == 2 && !wrap_len_ok);
    endfunction

    // Address of beat i, from the burst definition rather than an iterative update.
    function automatic logic [31:0] model_addr(input req_t r, input int i);
        longint unsigned a     = 64'(r.addr);
        longint unsigned incr  = 64'(1) << ((r.size > 2) ? 2 : r.size);
        longint unsigned total, base;
        bit wrap_ok = (r.burst == 2) && !model_unsup(r);
        if (r.burst == 0) return r.addr;
        if (wrap_ok) begin
            total = 64'(r.len + 1) * incr;
            base  = a - (a % total);
            return 32'(base + (((a - base) + 64'(i) * incr) % total));
        end
        return 32'(a + 64'(i) * incr);
    endfunction

    function automatic req_t mk(input logic [31:0] a, input int len, input int size,
                                input int burst, input logic [15:0] errs, input int stall);
        req_t r;
        r.addr = a; r.len = len; r.size = size; r.burst = burst;
        r.errs = errs; r.stall = stall; r.hold = 2;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        case ($urandom_range(0, 2))
            0:       r.addr = $urandom;
            1:       r.addr = 32'h0000_0F00 | 32'($urandom_range(0, 255));
            default: r.addr = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
        endcase
        r.len   = $urandom_range(0, 7);
        r.size  = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
        r.burst = $urandom_range(0, 3);
        r.errs  = 16'($urandom & $urandom & $urandom);
        r.stall = $urandom_range(0, 2);
        r.hold  = $urandom_range(0, 3);
        return r;
    endfunction

    // One complete transaction; the model predicts which side wins the arbitration.
    task automatic do_txn(input bit wv, input bit rv, input req_t wq, input req_t rq,
                          input string tag);
        bit          gw;
        req_t        q;
        logic [31:0] ea;
        bit          anyerr, uns;
        int          w;
        gw  = wv && (!rv || !last_wr);
        q   = gw ? wq : rq;
        uns = model_unsup(q);
        anyerr = 1'b0;

        @(negedge clk);
        wr_req_addr = wq.addr; wr_req_len = 4'(wq.len);
        wr_req_size = 3'(wq.size); wr_req_burst = 2'(wq.burst);
        rd_req_addr = rq.addr; rd_req_len = 4'(rq.len);
        rd_req_size = 3'(rq.size); rd_req_burst = 2'(rq.burst);
        wr_req_valid = wv; rd_req_valid = rv;
        #1;
        check({tag, " grant"}, {wr_req_ready, rd_req_ready}, {gw, !gw});
        last_wr = gw;

        @(negedge clk);
        #1;
        check({tag, " ready one cycle"}, {wr_req_ready, rd_req_ready}, 2'b00);
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;

        for (int i = 0; i <= q.len; i++) begin
            ea = model_addr(q, i);
            for (int s = 0; s < q.stall; s++) begin
                apb_done = 1'($urandom_range(0, 1));  // must be ignored outside WAIT
                apb_err  = 1'b1;
                #1;
                check({tag, " stalled start"}, {apb_start, rd_beat_valid}, 2'b00);
                @(negedge clk);
                #1;
            end
            apb_done = 1'b0; apb_err = 1'b0;
            if (gw) wfifo_empty = 1'b0; else rfifo_full = 1'b0;
            #1;
            check({tag, " start"}, apb_start, 1'b1);
            check({tag, " addr"}, apb_addr, ea);
            check({tag, " sel/write"}, {apb_sel, apb_write}, {(ea[SEL] ? 2'b10 : 2'b01), gw});
            @(negedge clk);
            wfifo_empty = 1'b1; rfifo_full = 1'b1;
            #1;
            check({tag, " start pulse"}, apb_start, 1'b0);
            w = $urandom_range(0, 2);
            for (int k = 0; k < w; k++) begin
                check({tag, " wait addr"}, {apb_addr, apb_write, rd_beat_valid}, {ea, gw, 1'b0});
                @(negedge clk);
                #1;
            end
            apb_done = 1'b1; apb_err = q.errs[i];
            anyerr |= q.errs[i];
            #1;
            if (!gw) begin
                check({tag, " rd beat"}, {rd_beat_valid, rd_beat_resp, rd_beat_last},
                      {1'b1, ((q.errs[i] || uns) ? 2'b10 : 2'b00), (i == q.len)});
            end else begin
                check({tag, " no rd beat"}, rd_beat_valid, 1'b0);
            end
            @(negedge clk);
            apb_done = 1'b0; apb_err = 1'b0;
            #1;
        end

        if (gw) begin
            for (int k = 0; k < q.hold; k++) begin
                check({tag, " bresp held"}, {wr_resp_valid, wr_resp},
                      {1'b1, ((anyerr || uns) ? 2'b10 : 2'b00)});
                @(negedge clk);
                #1;
            end
            check({tag, " bresp"}, {wr_resp_valid, wr_resp}, {1'b1, ((anyerr || uns) ? 2'b10 : 2'b00)});
            wr_resp_ready = 1'b1;
            @(negedge clk);
            wr_resp_ready = 1'b0;
            #1;
        end
        check({tag, " idle"}, {wr_resp_valid, apb_start, apb_sel}, 4'b0000);
    endtask

    req_t rq, wq;

    initial begin
        rst_n = 1'b0;
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        wr_req_addr = '0; wr_req_len = '0; wr_req_size = '0; wr_req_burst = '0;
        rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0; rd_req_burst = '0;
        wfifo_empty = 1'b1; rfifo_full = 1'b1;
        apb_done = 1'b0; apb_err = 1'b0; wr_resp_ready = 1'b0;
        last_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs",
              {wr_req_ready, rd_req_ready, apb_start, apb_write, apb_addr, apb_sel,
               rd_beat_valid, rd_beat_resp, rd_beat_last, wr_resp_valid, wr_resp}, 64'd0);
        rst_n = 1'b1;

        // Single write, INCR len 0.
        do_txn(1, 0, mk(32'h10, 0, 2, 1, 16'h0, 0), mk(0, 0, 2, 1, 0, 0), "wr single");
        // Read INCR crossing the slave-select bit.
        do_txn(0, 1, mk(0, 0, 2, 1, 0, 0), mk(32'hFF8, 3, 2, 1, 16'h0, 1), "rd incr");
        // Read WRAP.
        do_txn(0, 1, mk(0, 0, 2, 1, 0, 0), mk(32'h38, 3, 2, 2, 16'h0, 0), "rd wrap");
        // Both pending: alternate, write first since last grant was a read.
        for (int n = 0; n < 6; n++) begin
            do_txn(1, 1, mk(32'h200 + 32'(n * 16), 1, 2, 1, 16'h0, 0),
                   mk(32'h1300 + 32'(n * 16), 1, 2, 1, 16'h0, 0), "tie");
        end
        // Write-only stream.
        do_txn(1, 0, mk(32'h40, 0, 1, 1, 0, 0), mk(0, 0, 0, 0, 0, 0), "wr stream0");
        do_txn(1, 0, mk(32'h44, 1, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), "wr stream1");
        // Error on one beat of a write burst.
        do_txn(1, 0, mk(32'h80, 3, 2, 1, 16'h0004, 0), mk(0, 0, 0, 0, 0, 0), "wr err");
        // Reserved burst type on a read.
        do_txn(0, 1, mk(0, 0, 0, 0, 0, 0), mk(32'h90, 1, 2, 3, 16'h0, 0), "rd burst11");
        // Write gated by empty FIFO for 5 cycles.
        do_txn(1, 0, mk(32'hA0, 0, 2, 1, 0, 5), mk(0, 0, 0, 0, 0, 0), "wr stall");

        // Reset while a write beat is in WAIT.
        @(negedge clk);
        wr_req_addr = 32'h100; wr_req_len = 4'd3; wr_req_size = 3'd2; wr_req_burst = 2'b01;
        wr_req_valid = 1'b1;
        #1;
        check("rst burst grant", wr_req_ready, 1'b1);
        @(negedge clk);
        wr_req_valid = 1'b0; wfifo_empty = 1'b0;
        #1;
        check("rst burst start", apb_start, 1'b1);
        @(negedge clk);
        wfifo_empty = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid-burst reset outputs",
              {wr_req_ready, rd_req_ready, apb_start, apb_write, apb_addr, apb_sel,
               rd_beat_valid, rd_beat_resp, rd_beat_last, wr_resp_valid, wr_resp}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_wr = 1'b0;
        do_txn(1, 1, mk(32'h300, 0, 2, 1, 0, 0), mk(32'h400, 0, 2, 1, 0, 0), "post-rst tie");

        // Randomized bursts.
        for (int n = 0; n < 40; n++) begin
            bit wv, rv;
            wv = 1'($urandom_range(0, 1));
            rv = wv ? 1'($urandom_range(0, 1)) : 1'b1;
            wq = rand_req();
            rq = rand_req();
            do_txn(wv, rv, wq, rq, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_txn_scheduler.md
Name: apb_txn_scheduler

Overview:
Sequences AXI bursts onto the single APB master in the AXI-to-APB bridge. It arbitrates round-robin between pending write (AW) and read (AR) requests from the AXI slave front-ends. It then expands each burst into per-beat APB commands, generating beat addresses for FIXED, INCR and WRAP bursts and decoding PSEL. It gates each beat on FIFO data or space, and returns write responses and per-beat read status to the front-ends.

Parameters:
ADDR_WIDTH, 32, AXI/APB address width
SEL_BIT, 12, address bit that selects APB slave (0 -> psel 2'b01, 1 -> psel 2'b10)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_req_valid  in  1  AW request pending (from slave_axi_reader)
wr_req_ready  out  1  AW request accepted
wr_req_addr  in  ADDR_WIDTH  AWADDR
wr_req_len  in  4  AWLEN (beats-1)
wr_req_size  in  3  AWSIZE
wr_req_burst  in  2  AWBURST
rd_req_valid  in  1  AR request pending (from slave_axi_writer)
rd_req_ready  out  1  AR request accepted
rd_req_addr  in  ADDR_WIDTH  ARADDR
rd_req_len  in  4  ARLEN
rd_req_size  in  3  ARSIZE
rd_req_burst  in  2  ARBURST
wfifo_empty  in  1  write FIFO empty
rfifo_full  in  1  read FIFO full
apb_start  out  1  one-cycle pulse: launch one APB transfer
apb_write  out  1  direction of current transfer
apb_addr  out  ADDR_WIDTH  beat address
apb_sel  out  2  one-hot PSEL
apb_done  in  1  APB transfer completed (PREADY seen in ACCESS)
apb_err  in  1  PSLVERR, valid with apb_done
rd_beat_valid  out  1  one-cycle pulse per completed read beat
rd_beat_resp  out  2  RRESP for that beat
rd_beat_last  out  1  final beat of read burst
wr_resp_valid  out  1  write burst complete
wr_resp  out  2  BRESP
wr_resp_ready  in  1  front-end accepts response

Behaviour:
- Reset: all outputs 0; state IDLE; beat_cnt 0; last_grant = READ, so write wins the first tie. Reset mid-burst abandons the burst without completion.
- States: IDLE, SETUP, WAIT, RESP.
- IDLE, arbitration: only one valid -> grant it. Both valid -> grant opposite of last_grant. The req_ready for the granted side is asserted combinationally in the same cycle and is at most one cycle wide. addr/len/size/burst/direction are captured, last_grant is updated, err_sticky is cleared, and the state moves to SETUP.
- SETUP: stall while (write and wfifo_empty) or (read and rfifo_full). Otherwise pulse apb_start for exactly one cycle and go to WAIT. apb_addr, apb_sel and apb_write are stable from SETUP entry until apb_done.
- WAIT: hold until apb_done. On done:
  - Write: err_sticky |= apb_err.
  - Read: rd_beat_valid=1, rd_beat_resp = apb_err ? 2'b10 : 2'b00 (forced 2'b10 if the request was flagged unsupported), rd_beat_last = (beat_cnt==len).
  - If beat_cnt==len: write -> RESP, read -> IDLE. Else beat_cnt++, advance the address, go to SETUP.
  - apb_done outside WAIT is ignored.
- RESP: wr_resp_valid=1, wr_resp = err_sticky ? 2'b10 : 2'b00. Hold until wr_resp_ready, then go to IDLE. Both valid and resp stay stable while waiting.
- Address arithmetic (incr = 1<<size):
  - FIXED (00): address unchanged.
  - INCR (01): addr + incr, ADDR_WIDTH wrap-around.
  - WRAP (10): total = (len+1)<<size; next = (addr & ~(total-1)) | ((addr+incr) & (total-1)). WRAP with len not in {1,3,7,15} is treated as INCR and flagged unsupported.
  - burst 11 is treated as INCR and flagged unsupported.
  - size>2 is clamped to 2 and flagged unsupported.
  - Unsupported -> SLVERR on all read beats and on BRESP. Beats are still executed so FIFOs stay balanced.
- apb_sel = addr[SEL_BIT] ? 2'b10 : 2'b01, recomputed per beat, so an INCR burst may cross slaves.
- Minimum beat throughput: SETUP + WAIT = 2 cycles plus APB wait states. No new request is accepted until the current burst fully completes; the bridge is non-pipelined.

Test Plan:
- Single write addr 0x0000_0010, len 0, size 2, INCR; apb_done after 2 cycles, apb_err 0 -> one apb_start, apb_addr 0x10, apb_sel 01, apb_write 1; wr_resp 00 held until wr_resp_ready.
- Read INCR len 3, size 2 at 0x0000_0FF8 -> addrs 0FF8, 0FFC, 1000, 1004; apb_sel 01, 01, 10, 10; four rd_beat_valid pulses, rd_beat_last only on the 4th.
- Read WRAP len 3, size 2 at 0x0000_0038 -> addrs 38, 3C, 30, 34.
- wr_req_valid and rd_req_valid held high together, three bursts each -> grants W, R, W, R, W, R. A write-only stream gets consecutive grants.
- Write len 3 with apb_err=1 on beat 2 only -> all 4 beats issued, wr_resp 10. Read len 1 with burst 11 -> both beats resp 10.
- wfifo_empty held 5 cycles in SETUP -> no apb_start until it deasserts. Reset asserted in WAIT -> all outputs 0 immediately; next request granted as write on a tie.
